// File: rtl/fp16_dot_accumulator_if.sv
// Stream bundle between the product source, the dot-product accumulator
// and the activation/writeback consumer.
interface fp16_dot_accumulator_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_product;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_sum;
  logic [CNT_W-1:0] out_count;

  // Upstream producer and downstream consumer side.
  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  // Accumulator side.
  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );
endinterface

// File: rtl/fp16_dot_accumulator.sv
// Half-precision dot-product accumulator: sums a stream of 16-bit products
// (no denormals/Inf/NaN, 16'h0000 is the only zero) with a two-stage
// align/add datapath, truncating, and reports the sum when in_last closes.
module fp16_dot_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp16_dot_accumulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ALIGN, ADD, DONE} state_t;

  state_t           state;
  logic [15:0]      acc;
  logic [15:0]      prod_q;
  logic             last_q;
  logic [CNT_W-1:0] count;
  logic             out_valid_q;
  logic [15:0]      out_sum_q;
  logic [CNT_W-1:0] out_count_q;

  // Operands captured at the end of ALIGN.
  logic             bypass_q;
  logic [15:0]      bypass_word_q;
  logic             sign_q;
  logic             sub_q;
  logic [4:0]       exp_q;
  logic [10:0]      big_sig_q;
  logic [10:0]      small_sig_q;

  // Alignment: pick the larger magnitude, right-shift the other's significand.
  logic             acc_big;
  logic [14:0]      big_mag;
  logic [14:0]      small_mag;
  logic [4:0]       exp_diff;
  logic [10:0]      small_shifted;
  logic             bypass;
  logic [15:0]      bypass_word;

  assign acc_big       = (acc[14:0] >= prod_q[14:0]);
  assign big_mag       = acc_big ? acc[14:0] : prod_q[14:0];
  assign small_mag     = acc_big ? prod_q[14:0] : acc[14:0];
  assign exp_diff      = big_mag[14:10] - small_mag[14:10];
  assign small_shifted = (exp_diff >= 5'd11) ? 11'd0 : ({1'b1, small_mag[9:0]} >> exp_diff);
  assign bypass        = (acc == 16'h0000) || (prod_q == 16'h0000);
  assign bypass_word   = (acc == 16'h0000) ? prod_q : acc;

  // Add/subtract and normalise the aligned significands.
  logic [11:0]      sum12;
  logic [10:0]      diff11;
  logic [3:0]       lz;
  logic [9:0]       norm_mant;
  logic [15:0]      result;
  logic [CNT_W-1:0] count_next;

  assign sum12      = {1'b0, big_sig_q} + {1'b0, small_sig_q};
  assign diff11     = big_sig_q - small_sig_q;
  assign norm_mant  = 10'(diff11 << lz);
  assign count_next = (&count) ? count : count + 1'b1;

  // Leading-zero count of the difference; the highest set bit wins.
  always_comb begin
    lz = 4'd0;
    for (int i = 0; i < 11; i++) begin
      if (diff11[i]) lz = 4'(10 - i);
    end
  end

  // Result selection: zero bypass, same-sign carry, or cancellation renormalise.
  always_comb begin
    result = 16'h0000;
    if (bypass_q) begin
      result = bypass_word_q;
    end else if (!sub_q) begin
      if (sum12[11]) begin
        if (exp_q == 5'd31) result = {sign_q, 5'h1F, 10'h3FF};
        else                result = {sign_q, exp_q + 5'd1, sum12[10:1]};
      end else begin
        result = {sign_q, exp_q, sum12[9:0]};
      end
    end else if (diff11 != 11'd0) begin
      if ({1'b0, lz} <= exp_q) result = {sign_q, exp_q - 5'(lz), norm_mant};
    end
  end

  // Control FSM and all datapath state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      acc           <= 16'h0000;
      prod_q        <= 16'h0000;
      last_q        <= 1'b0;
      count         <= '0;
      out_valid_q   <= 1'b0;
      out_sum_q     <= 16'h0000;
      out_count_q   <= '0;
      bypass_q      <= 1'b0;
      bypass_word_q <= 16'h0000;
      sign_q        <= 1'b0;
      sub_q         <= 1'b0;
      exp_q         <= 5'd0;
      big_sig_q     <= 11'd0;
      small_sig_q   <= 11'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            prod_q <= bus.in_product;
            last_q <= bus.in_last;
            state  <= ALIGN;
          end
        end
        ALIGN: begin
          bypass_q      <= bypass;
          bypass_word_q <= bypass_word;
          sign_q        <= acc_big ? acc[15] : prod_q[15];
          sub_q         <= acc[15] ^ prod_q[15];
          exp_q         <= big_mag[14:10];
          big_sig_q     <= {1'b1, big_mag[9:0]};
          small_sig_q   <= small_shifted;
          state         <= ADD;
        end
        ADD: begin
          acc   <= result;
          count <= count_next;
          if (last_q) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= result;
            out_count_q <= count_next;
            state       <= DONE;
          end else begin
            state <= IDLE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            acc         <= 16'h0000;
            count       <= '0;
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
endmodule

// File: tb/tb_fp16_dot_accumulator.sv
// Directed bench for fp16_dot_accumulator with a value-level reference model.
module tb_fp16_dot_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp16_dot_accumulator_if #(.CNT_W(8)) bus();

  fp16_dot_accumulator #(.CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  logic [15:0] macc = 16'h0000;
  logic [7:0]  mcnt = 8'd0;
  logic [23:0] expq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: treat each word as an exact integer sig*2^e, truncate the
  // smaller value to the larger one's LSB weight, add exactly, re-encode.
  function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
    longint va, vb, vbig, vsmall, r;
    int eb, p, e;
    logic sr;
    logic [63:0] m;
    if (a == 16'h0000) return b;
    if (b == 16'h0000) return a;
    va = longint'({1'b1, a[9:0]}) << a[14:10];
    vb = longint'({1'b1, b[9:0]}) << b[14:10];
    if (va >= vb) begin vbig = va; vsmall = vb; eb = int'(a[14:10]); sr = a[15]; end
    else          begin vbig = vb; vsmall = va; eb = int'(b[14:10]); sr = b[15]; end
    vsmall = (vsmall >> eb) << eb;
    r = (a[15] == b[15]) ? vbig + vsmall : vbig - vsmall;
    if (r == 0) return 16'h0000;
    p = 0;
    for (int i = 0; i < 63; i++) if (r[i]) p = i;
    e = p - 10;
    if (e > 31) return {sr, 15'h7FFF};
    if (e < 0) return 16'h0000;
    m = 64'(r >> e);
    return {sr, 5'(e), m[9:0]};
  endfunction

  task automatic model_add(input logic [15:0] w, input logic l);
    macc = fadd(macc, w);
    mcnt = (mcnt == 8'hFF) ? mcnt : mcnt + 8'd1;
    if (l) begin
      expq.push_back({macc, mcnt});
      macc = 16'h0000;
      mcnt = 8'd0;
    end
  endtask

  // Offer one term, wait for its accept edge, then check the busy window.
  task automatic send(input logic [15:0] w, input logic l);
    int n = 0;
    bus.in_product = w;
    bus.in_last    = l;
    bus.in_valid   = 1'b1;
    while (bus.in_ready !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 40) begin check("accept_timeout", 0, 1); break; end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    model_add(w, l);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k < 3) begin
        check("in_ready_busy", bus.in_ready, 0);
        check("out_valid_early", bus.out_valid, 0);
      end else if (l) begin
        check("out_valid_latency", bus.out_valid, 1);
      end else begin
        check("in_ready_back", bus.in_ready, 1);
      end
    end
  endtask

  // Wait for a result, check literal values, optionally stall, then accept.
  task automatic take(input logic [15:0] es, input logic [7:0] ec, input int hold);
    int n = 0;
    while (bus.out_valid !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 40) begin check("result_timeout", 0, 1); break; end
    end
    check("lit_sum", bus.out_sum, es);
    check("lit_count", bus.out_count, ec);
    if (hold > 0) begin
      bus.in_product = 16'h3C00;
      bus.in_last    = 1'b1;
      bus.in_valid   = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        check("hold_sum", bus.out_sum, es);
        check("hold_count", bus.out_count, ec);
        check("hold_valid", bus.out_valid, 1);
        check("hold_in_ready", bus.in_ready, 0);
      end
      bus.in_valid = 1'b0;
    end
    $display("result sum=%h count=%0d (want %h/%0d)", bus.out_sum, bus.out_count, es, ec);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("post_valid", bus.out_valid, 0);
    check("post_in_ready", bus.in_ready, 1);
  endtask

  // Model compare on every cycle a result is presented.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (expq.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        check("model_sum", bus.out_sum, expq[0][23:8]);
        check("model_count", bus.out_count, expq[0][7:0]);
      end
    end
  end

  // Retire the expected result on the handshake edge.
  always @(posedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready && expq.size() > 0)
      void'(expq.pop_front());
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_product = 16'h0000;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;

    // Pin the reference model with hand-derived sums.
    check("pin_1p1", fadd(16'h3C00, 16'h3C00), 16'h4000);
    check("pin_2p5m1", fadd(16'h4100, 16'hBC00), 16'h3E00);
    check("pin_cancel", fadd(16'h4400, 16'hC400), 16'h0000);
    check("pin_sat", fadd(16'h7FFF, 16'h7FFF), 16'h7FFF);
    check("pin_shiftout", fadd(16'h3C00, 16'h0400), 16'h3C00);
    check("pin_neg", fadd(16'hC000, 16'h3C00), 16'hBC00);

    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_sum", bus.out_sum, 16'h0000);
    check("rst_out_count", bus.out_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);

    send(16'h3C00, 1'b0); send(16'h3C00, 1'b1);
    take(16'h4000, 8'd2, 0);

    send(16'h3C00, 1'b0); send(16'h3E00, 1'b0); send(16'hBC00, 1'b1);
    take(16'h3E00, 8'd3, 0);

    send(16'h4400, 1'b0); send(16'hC400, 1'b1);
    take(16'h0000, 8'd2, 0);
    send(16'h3800, 1'b1);
    take(16'h3800, 8'd1, 0);

    send(16'h7FFF, 1'b0); send(16'h7FFF, 1'b1);
    take(16'h7FFF, 8'd2, 0);
    send(16'h3C00, 1'b0); send(16'h0400, 1'b1);
    take(16'h3C00, 8'd2, 0);

    send(16'hC000, 1'b0); send(16'h3C00, 1'b1);
    take(16'hBC00, 8'd2, 0);

    send(16'h0000, 1'b1);
    take(16'h0000, 8'd1, 0);

    send(16'h3C00, 1'b0); send(16'h3C00, 1'b1);
    take(16'h4000, 8'd2, 10);

    // Reset landing in the ALIGN cycle of a term.
    bus.in_product = 16'h4000;
    bus.in_last    = 1'b0;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    macc = 16'h0000;
    mcnt = 8'd0;
    expq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'h3C00, 1'b1);
    take(16'h3C00, 8'd1, 0);

    check("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
